// File: rtl/panel_sprite_compositor_if.sv
// Pixel-stream and sprite-ROM bundle for panel_sprite_compositor.
//   frame_start   : one-cycle pulse on the first active pixel of a frame
//   pix_valid_in  : pixel qualifier for x / y / bg_color
//   x, y          : active pixel column / row
//   bg_color      : background RGB444 for (x, y)
//   sprite_addr   : address to the external synchronous sprite+palette ROM
//   sprite_color  : ROM data, valid one cycle after sprite_addr
//   pix_color     : composited RGB444 pixel (3 cycles after the input pixel)
//   pix_valid_out : pix_valid_in delayed to line up with pix_color
// "master" is the timing generator / ROM side, "slave" is the compositor.
interface panel_sprite_compositor_if #(
    parameter int ADDR_W = 13
) ();
    logic              frame_start;
    logic              pix_valid_in;
    logic [10:0]       x;
    logic [9:0]        y;
    logic [11:0]       bg_color;
    logic [ADDR_W-1:0] sprite_addr;
    logic [11:0]       sprite_color;
    logic [11:0]       pix_color;
    logic              pix_valid_out;

    modport master (
        output frame_start, pix_valid_in, x, y, bg_color, sprite_color,
        input  sprite_addr, pix_color, pix_valid_out
    );

    modport slave (
        input  frame_start, pix_valid_in, x, y, bg_color, sprite_color,
        output sprite_addr, pix_color, pix_valid_out
    );
endinterface

// File: rtl/panel_sprite_compositor.sv
// Front-panel sprite overlay engine.
// A calibration frame is scanned for LED / switch marker colours to build a
// slot table of sprite anchors; afterwards a state-dependent sprite is drawn
// at every valid anchor through a fixed 3-stage pipeline.
// Ports:
//   clk, reset      : pixel clock, synchronous active-high reset
//   bus (slave)     : pixel stream in, sprite ROM port, composited pixel out
//   leds_status     : 1 = LED lit, bit i is LED slot i (latched at frame_start)
//   sw_sprite       : 2-bit sprite number per switch (latched at frame_start)
//   cursor_index    : highlighted switch slot, sampled in stage 1
//   recalibrate     : request a new capture frame (honoured in READY only)
//   locked          : slot table valid
//   capture_error   : marker count mismatch at the end of the last capture
module panel_sprite_compositor #(
    parameter int          NUM_LEDS     = 36,
    parameter int          NUM_SWITCHES = 25,
    parameter int          SPRITE_W     = 32,
    parameter int          SPRITE_H     = 32,
    parameter int          OFF_X        = 10,
    parameter int          OFF_Y        = 6,
    parameter int          ADDR_W       = 13,
    parameter int          LED_ON_SPR   = 3,
    parameter int          LED_OFF_SPR  = 4,
    parameter logic [11:0] MARK_LED     = 12'hF00,
    parameter logic [11:0] MARK_SW      = 12'h0F0,
    parameter logic [11:0] TRANSP       = 12'h333,
    parameter logic [11:0] CURSOR_KEY   = 12'h1BF,
    localparam int         CUR_W        = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    panel_sprite_compositor_if.slave  bus,
    input  logic [NUM_LEDS-1:0]       leds_status,
    input  logic [2*NUM_SWITCHES-1:0] sw_sprite,
    input  logic [CUR_W-1:0]          cursor_index,
    input  logic                      recalibrate,
    output logic                      locked,
    output logic                      capture_error
);
    localparam int LCW = $clog2(NUM_LEDS + 1);
    localparam int SCW = $clog2(NUM_SWITCHES + 1);
    localparam int LIW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
    localparam int SIW = (NUM_SWITCHES > 1) ? $clog2(NUM_SWITCHES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_READY} state_t;
    state_t state_q, state_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.frame_start) state_d = S_CAPTURE;
            S_CAPTURE: if (bus.frame_start) state_d = S_READY;
            S_READY:   if (recalibrate)     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    logic clear_tbl, finish_cap, cap_en, hit_en;
    assign clear_tbl  = (state_q == S_READY) && (state_d == S_IDLE);
    assign finish_cap = (state_q == S_CAPTURE) && (state_d == S_READY);
    // The frame_start pixel belongs to the frame it opens: it is captured when
    // it opens the capture frame and drawn when it opens the first READY frame.
    assign cap_en = bus.pix_valid_in &&
                    (((state_q == S_IDLE) && bus.frame_start) ||
                     ((state_q == S_CAPTURE) && !bus.frame_start));
    assign hit_en = bus.pix_valid_in &&
                    ((state_q == S_READY) || finish_cap);

    // Sprite origin is saturated at capture time so the table holds origins.
    logic [10:0] org_x;
    logic [9:0]  org_y;
    assign org_x = (bus.x >= 11'(OFF_X)) ? bus.x - 11'(OFF_X) : 11'd0;
    assign org_y = (bus.y >= 10'(OFF_Y)) ? bus.y - 10'(OFF_Y) : 10'd0;

    logic [LCW-1:0] led_cnt_q;
    logic [SCW-1:0] sw_cnt_q;
    logic           over_q, locked_q, cap_err_q;
    logic           led_mark, sw_mark, led_wr, sw_wr;
    assign led_mark = cap_en && (bus.bg_color == MARK_LED);
    assign sw_mark  = cap_en && (bus.bg_color == MARK_SW);
    assign led_wr   = led_mark && (led_cnt_q < LCW'(NUM_LEDS));
    assign sw_wr    = sw_mark && (sw_cnt_q < SCW'(NUM_SWITCHES));

    always_ff @(posedge clk) begin
        if (reset || clear_tbl) begin
            led_cnt_q <= '0;
            sw_cnt_q  <= '0;
            over_q    <= 1'b0;
        end else begin
            if (led_wr) led_cnt_q <= led_cnt_q + 1'b1;
            if (sw_wr)  sw_cnt_q  <= sw_cnt_q + 1'b1;
            if ((led_mark && !led_wr) || (sw_mark && !sw_wr)) over_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            locked_q  <= 1'b0;
            cap_err_q <= 1'b0;
        end else if (clear_tbl) begin
            locked_q  <= 1'b0;
        end else if (finish_cap) begin
            locked_q  <= 1'b1;
            cap_err_q <= over_q || (led_cnt_q != LCW'(NUM_LEDS)) ||
                         (sw_cnt_q != SCW'(NUM_SWITCHES));
        end
    end
    assign locked        = locked_q;
    assign capture_error = cap_err_q;

    // Panel state is frozen per frame; the frame_start pixel already sees the
    // value being latched so the whole new frame is consistent.
    logic [NUM_LEDS-1:0]       leds_q, leds_eff;
    logic [2*NUM_SWITCHES-1:0] sw_q, sw_eff;
    always_ff @(posedge clk) begin
        if (reset) begin
            leds_q <= '0;
            sw_q   <= '0;
        end else if (bus.frame_start) begin
            leds_q <= leds_status;
            sw_q   <= sw_sprite;
        end
    end
    assign leds_eff = bus.frame_start ? leds_status : leds_q;
    assign sw_eff   = bus.frame_start ? sw_sprite : sw_q;

    // Slot tables: one register set and window comparator per slot.
    logic [10:0]             led_sx [NUM_LEDS];
    logic [9:0]              led_sy [NUM_LEDS];
    logic [NUM_LEDS-1:0]     led_hit;
    logic [10:0]             sw_sx  [NUM_SWITCHES];
    logic [9:0]              sw_sy  [NUM_SWITCHES];
    logic [NUM_SWITCHES-1:0] sw_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LEDS; gi++) begin : g_led
            logic        vld_q;
            logic [10:0] sx_q;
            logic [9:0]  sy_q;
            always_ff @(posedge clk) begin
                if (reset || clear_tbl) begin
                    vld_q <= 1'b0;
                end else if (led_wr && (led_cnt_q == LCW'(gi))) begin
                    vld_q <= 1'b1;
                    sx_q  <= org_x;
                    sy_q  <= org_y;
                end
            end
            assign led_sx[gi]  = sx_q;
            assign led_sy[gi]  = sy_q;
            assign led_hit[gi] = vld_q && (bus.x >= sx_q) &&
                                 ({1'b0, bus.x} < ({1'b0, sx_q} + 12'(SPRITE_W))) &&
                                 (bus.y >= sy_q) &&
                                 ({1'b0, bus.y} < ({1'b0, sy_q} + 11'(SPRITE_H)));
        end
        for (gi = 0; gi < NUM_SWITCHES; gi++) begin : g_sw
            logic        vld_q;
            logic [10:0] sx_q;
            logic [9:0]  sy_q;
            always_ff @(posedge clk) begin
                if (reset || clear_tbl) begin
                    vld_q <= 1'b0;
                end else if (sw_wr && (sw_cnt_q == SCW'(gi))) begin
                    vld_q <= 1'b1;
                    sx_q  <= org_x;
                    sy_q  <= org_y;
                end
            end
            assign sw_sx[gi]  = sx_q;
            assign sw_sy[gi]  = sy_q;
            assign sw_hit[gi] = vld_q && (bus.x >= sx_q) &&
                                ({1'b0, bus.x} < ({1'b0, sx_q} + 12'(SPRITE_W))) &&
                                (bus.y >= sy_q) &&
                                ({1'b0, bus.y} < ({1'b0, sy_q} + 11'(SPRITE_H)));
        end
    endgenerate

    // Stage 1 combinational: priority select (LEDs first, lowest index wins).
    logic [LIW-1:0]    led_sel;
    logic [SIW-1:0]    sw_sel;
    logic              led_any, sw_any, hit, cur_hit;
    logic [10:0]       sel_sx;
    logic [9:0]        sel_sy;
    logic [7:0]        spr;
    logic [ADDR_W-1:0] addr_d;

    always_comb begin
        led_sel = '0;
        sw_sel  = '0;
        for (int i = NUM_LEDS - 1; i >= 0; i--)
            if (led_hit[i]) led_sel = LIW'(i);
        for (int i = NUM_SWITCHES - 1; i >= 0; i--)
            if (sw_hit[i]) sw_sel = SIW'(i);
        led_any = |led_hit;
        sw_any  = |sw_hit;
        hit     = hit_en && (led_any || sw_any);
        if (led_any) begin
            sel_sx = led_sx[led_sel];
            sel_sy = led_sy[led_sel];
            spr    = leds_eff[led_sel] ? 8'(LED_ON_SPR) : 8'(LED_OFF_SPR);
        end else begin
            sel_sx = sw_sx[sw_sel];
            sel_sy = sw_sy[sw_sel];
            spr    = {6'd0, sw_eff[2*sw_sel +: 2]};
        end
        // Out-of-range cursor values never equal a real slot index.
        cur_hit = hit && !led_any && (32'(sw_sel) == 32'(cursor_index));
        addr_d  = '0;
        if (hit)
            addr_d = ADDR_W'(32'(spr) * 32'(SPRITE_W * SPRITE_H) +
                             32'(bus.y - sel_sy) * 32'(SPRITE_W) +
                             32'(bus.x - sel_sx));
    end

    // Pipeline registers: stage 1 (address), stage 2 (ROM read), stage 3 (pixel).
    logic [ADDR_W-1:0] addr_q;
    logic              s1_vld_q, s1_hit_q, s1_cur_q;
    logic [11:0]       s1_bg_q;
    logic              s2_vld_q, s2_hit_q, s2_cur_q;
    logic [11:0]       s2_bg_q;
    logic [11:0]       pix_q, pix_d;
    logic              pvo_q;

    always_comb begin
        pix_d = s2_bg_q;
        if (!s2_vld_q) begin
            pix_d = '0;
        end else if (s2_hit_q) begin
            if (bus.sprite_color == TRANSP)
                pix_d = s2_bg_q;
            else if (bus.sprite_color == CURSOR_KEY)
                pix_d = s2_cur_q ? CURSOR_KEY : s2_bg_q;
            else
                pix_d = bus.sprite_color;
        end else if ((s2_bg_q == MARK_LED) || (s2_bg_q == MARK_SW)) begin
            pix_d = TRANSP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q   <= '0;
            s1_vld_q <= 1'b0;
            s1_hit_q <= 1'b0;
            s1_cur_q <= 1'b0;
            s1_bg_q  <= '0;
            s2_vld_q <= 1'b0;
            s2_hit_q <= 1'b0;
            s2_cur_q <= 1'b0;
            s2_bg_q  <= '0;
            pix_q    <= '0;
            pvo_q    <= 1'b0;
        end else begin
            addr_q   <= addr_d;
            s1_vld_q <= bus.pix_valid_in;
            s1_hit_q <= hit;
            s1_cur_q <= cur_hit;
            s1_bg_q  <= bus.bg_color;
            s2_vld_q <= s1_vld_q;
            s2_hit_q <= s1_hit_q;
            s2_cur_q <= s1_cur_q;
            s2_bg_q  <= s1_bg_q;
            pix_q    <= pix_d;
            pvo_q    <= s2_vld_q;
        end
    end

    assign bus.sprite_addr   = addr_q;
    assign bus.pix_color     = pix_q;
    assign bus.pix_valid_out = pvo_q;
endmodule
